control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Hardwired control FSM that drives the datapath from the bus-master side. Each cycle it
//  asserts at most one source out-enable onto the shared 32-bit bus (one-hot src_sel) plus
//  the matching load enables, ALU op and memory strobes. It sequences instruction fetch
//  (T0-T2) and execute (T3-T6) for ALU, immediate, mul/div, mfhi/mflo, nop and halt.
// PARAMETERS
//  NSRC     24  width of src_sel; bit order R0..R15, HI, LO, ZHI, ZLO, PC, MDR, InPort, C
//  NREG     16  general registers; ra/rb/rc are 4-bit fields
// PORTS
//  clk        in   1   clock, all state changes on rising edge
//  reset      in   1   synchronous, active-high
//  run        in   1   leave IDLE and start fetching
//  ir         in   32  IR register contents; op=ir[31:27] ra=[26:23] rb=[22:19] rc=[18:15]
//  mem_ready  in   1   memory read data valid on MDR input this cycle
//  src_sel    out  24  one-hot bus source enable (all-zero = bus idle)
//  reg_in     out  16  one-hot register load enable (Rin)
//  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin   out 1 each  datapath load enables
//  IncPC      out  1   ALU passes bus+1 this cycle
//  Read       out  1   memory read strobe
//  alu_op     out  5   ALU opcode, valid when Zin=1
//  busy       out  1   FSM not in IDLE/HALT
//  halted     out  1   FSM in HALT
//  illegal_op out  1   undefined opcode trapped (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; every output 0. Reset wins over any state, including mid-instruction.
//  All outputs are combinational decodes of the registered state + ir (Moore w.r.t. state).
//  Invariant: popcount(src_sel)<=1 and popcount(reg_in)<=1 in every cycle.
//  States/actions:
//   IDLE : outputs 0; run=1 -> T0.
//   T0   : src PC, MARin, IncPC, Zin -> T1.
//   T1   : src ZLO, PCin, Read -> T1W.
//   T1W  : Read held; MDRin=mem_ready; mem_ready=1 -> T2, else stay (no timeout).
//   T2   : src MDR, IRin -> T3 (ir decoded from T3 onward).
//   T3   : ALU-R/ALU-I/neg/not: src R[rb], Yin. mul/div: src R[ra], Yin.
//          mfhi: src HI, reg_in[ra] -> T0. mflo: src LO, reg_in[ra] -> T0.
//          nop -> T0. halt -> HALT. undefined -> see CONFIGURATION.
//   T4   : ALU-R: src R[rc]; ALU-I: src C; neg/not: src R[rb]; mul/div: src R[rb]. All Zin.
//   T5   : src ZLO; mul/div: LOin -> T6; others: reg_in[ra] -> T0.
//   T6   : src ZHI, HIin -> T0.
//   HALT : halted=1, outputs otherwise 0; exits only on reset.
//  Opcodes: add 00011 sub 00100 shr 00101 shl 00110 ror 00111 rol 01000 and 01001 or 01010
//   addi 01011 andi 01100 ori 01101 mul 01110 div 01111 neg 10000 not 10001
//   mfhi 10111 mflo 11000 nop 11001 halt 11010.
//  alu_op = op, except addi->add, andi->and, ori->or. T0 alu_op is don't-care (IncPC rules).
//  run is ignored outside IDLE. ra=0 writes are allowed (no R0 special case).
// CONFIGURATION
//  SEQ_ILLEGAL_TRAP_EN defined: undefined op at T3 -> HALT with illegal_op=1 held until reset.
//  Not defined: undefined op treated as nop (T3 -> T0); illegal_op tied 0.
// STRUCTURE
//  Package seq_pkg: opcode localparams, state encoding, src_sel bit index constants
//   (SRC_HI=16, SRC_LO=17, SRC_ZHI=18, SRC_ZLO=19, SRC_PC=20, SRC_MDR=21, SRC_INP=22, SRC_C=23).
//  Sub-module reg_select: 4-bit field + enable -> 16-bit one-hot; instanced for src and dest.
// TESTING
//  1 Fetch, mem_ready low 2 cycles after T1 -> Read high 3 cycles, MDRin only on ready cycle,
//    IRin at T2; total fetch 5 cycles.
//  2 ir=add r1,r2,r3 -> T3 src_sel=bit2+Yin, T4 bit3+Zin alu_op=00011, T5 bit19+reg_in[1].
//  3 ir=addi r4,r5,C=-3 -> T4 src_sel=bit23, alu_op=00011; T5 reg_in[4]; back to T0.
//  4 ir=mul r6,r7 -> T4 src bit7 Zin; T5 bit19+LOin; T6 bit18+HIin; mfhi r8 -> bit16+reg_in[8].
//  5 halt -> halted=1, run toggling ignored; reset asserted at T4 of add -> next cycle IDLE,
//    all outputs 0, no reg_in pulse.
//  6 op=11111: with SEQ_ILLEGAL_TRAP_EN -> HALT, illegal_op=1; without -> T0, illegal_op=0.
//  All: assert one-hot invariants every cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the control sequencer: opcodes, FSM states,
// instruction classes and bus source bit positions.
package seq_pkg;

  localparam int unsigned NSRC = 24;
  localparam int unsigned NREG = 16;

  // Bus source bit positions above the general registers R0..R15.
  localparam int unsigned SRC_HI  = 16;
  localparam int unsigned SRC_LO  = 17;
  localparam int unsigned SRC_ZHI = 18;
  localparam int unsigned SRC_ZLO = 19;
  localparam int unsigned SRC_PC  = 20;
  localparam int unsigned SRC_MDR = 21;
  localparam int unsigned SRC_INP = 22;
  localparam int unsigned SRC_C   = 23;

  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpShr  = 5'b00101;
  localparam logic [4:0] OpShl  = 5'b00110;
  localparam logic [4:0] OpRor  = 5'b00111;
  localparam logic [4:0] OpRol  = 5'b01000;
  localparam logic [4:0] OpAnd  = 5'b01001;
  localparam logic [4:0] OpOr   = 5'b01010;
  localparam logic [4:0] OpAddi = 5'b01011;
  localparam logic [4:0] OpAndi = 5'b01100;
  localparam logic [4:0] OpOri  = 5'b01101;
  localparam logic [4:0] OpMul  = 5'b01110;
  localparam logic [4:0] OpDiv  = 5'b01111;
  localparam logic [4:0] OpNeg  = 5'b10000;
  localparam logic [4:0] OpNot  = 5'b10001;
  localparam logic [4:0] OpMfhi = 5'b10111;
  localparam logic [4:0] OpMflo = 5'b11000;
  localparam logic [4:0] OpNop  = 5'b11001;
  localparam logic [4:0] OpHalt = 5'b11010;

  typedef enum logic [3:0] {
    StIdle,
    StT0,
    StT1,
    StT1w,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StHalt
  } state_e;

  typedef enum logic [3:0] {
    ClsAluR,
    ClsAluI,
    ClsUnary,
    ClsMulDiv,
    ClsMfhi,
    ClsMflo,
    ClsNop,
    ClsHalt,
    ClsIllegal
  } op_class_e;

  // Groups opcodes by the execute sequence they follow.
  function automatic op_class_e decode_class(input logic [4:0] op);
    op_class_e cls;
    case (op)
      OpAdd, OpSub, OpShr, OpShl, OpRor, OpRol, OpAnd, OpOr: cls = ClsAluR;
      OpAddi, OpAndi, OpOri:                                  cls = ClsAluI;
      OpNeg, OpNot:                                           cls = ClsUnary;
      OpMul, OpDiv:                                           cls = ClsMulDiv;
      OpMfhi:                                                 cls = ClsMfhi;
      OpMflo:                                                 cls = ClsMflo;
      OpNop:                                                  cls = ClsNop;
      OpHalt:                                                 cls = ClsHalt;
      default:                                                cls = ClsIllegal;
    endcase
    return cls;
  endfunction

  // Immediate forms reuse the register-form ALU operation.
  function automatic logic [4:0] alu_map(input logic [4:0] op);
    logic [4:0] res;
    case (op)
      OpAddi:  res = OpAdd;
      OpAndi:  res = OpAnd;
      OpOri:   res = OpOr;
      default: res = op;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/reg_select.sv
// Register field decoder: 4-bit register number plus enable to a one-hot vector.
module reg_select
  import seq_pkg::*;
(
  input  logic [3:0]      field_i,
  input  logic            en_i,
  output logic [NREG-1:0] onehot_o
);

  // One-hot decode, all-zero when disabled.
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[field_i] = 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control FSM driving the shared-bus datapath.
// Optional feature: define SEQ_ILLEGAL_TRAP_EN to halt on undefined opcodes
// and raise illegal_op; otherwise undefined opcodes behave as nop.
module control_sequencer
  import seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic [NSRC-1:0] src_sel,
  output logic [NREG-1:0] reg_in,
  output logic            PCin,
  output logic            IRin,
  output logic            MARin,
  output logic            MDRin,
  output logic            Yin,
  output logic            Zin,
  output logic            HIin,
  output logic            LOin,
  output logic            IncPC,
  output logic            Read,
  output logic [4:0]      alu_op,
  output logic            busy,
  output logic            halted,
  output logic            illegal_op
);

  state_e state_q, state_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  op_class_e  cls;

  assign op  = ir[31:27];
  assign ra  = ir[26:23];
  assign rb  = ir[22:19];
  assign rc  = ir[18:15];
  assign cls = decode_class(op);

  // Low bits hold the immediate, which only the datapath consumes.
  logic unused_ir;
  assign unused_ir = ^ir[14:0];

  logic [NSRC-1:0] src_fixed;
  logic            src_reg_en;
  logic [3:0]      src_reg_field;
  logic [NREG-1:0] src_reg_oh;
  logic            dst_en;

`ifdef SEQ_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // State register and sticky illegal flag; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal_op = illegal_q;
`else
  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign illegal_op = 1'b0;
`endif

  // Next-state and control decode from registered state and IR.
  always_comb begin
    state_d       = state_q;
`ifdef SEQ_ILLEGAL_TRAP_EN
    illegal_d     = illegal_q;
`endif
    src_fixed     = '0;
    src_reg_en    = 1'b0;
    src_reg_field = rb;
    dst_en        = 1'b0;
    PCin          = 1'b0;
    IRin          = 1'b0;
    MARin         = 1'b0;
    MDRin         = 1'b0;
    Yin           = 1'b0;
    Zin           = 1'b0;
    HIin          = 1'b0;
    LOin          = 1'b0;
    IncPC         = 1'b0;
    Read          = 1'b0;
    alu_op        = 5'd0;

    case (state_q)
      StIdle: begin
        if (run) state_d = StT0;
      end
      StT0: begin
        src_fixed[SRC_PC] = 1'b1;
        MARin             = 1'b1;
        IncPC             = 1'b1;
        Zin               = 1'b1;
        state_d           = StT1;
      end
      StT1: begin
        src_fixed[SRC_ZLO] = 1'b1;
        PCin               = 1'b1;
        Read               = 1'b1;
        state_d            = StT1w;
      end
      StT1w: begin
        // Wait indefinitely for memory; capture data only when it is valid.
        Read  = 1'b1;
        MDRin = mem_ready;
        if (mem_ready) state_d = StT2;
      end
      StT2: begin
        src_fixed[SRC_MDR] = 1'b1;
        IRin               = 1'b1;
        state_d            = StT3;
      end
      StT3: begin
        case (cls)
          ClsAluR, ClsAluI, ClsUnary: begin
            src_reg_en    = 1'b1;
            src_reg_field = rb;
            Yin           = 1'b1;
            state_d       = StT4;
          end
          ClsMulDiv: begin
            src_reg_en    = 1'b1;
            src_reg_field = ra;
            Yin           = 1'b1;
            state_d       = StT4;
          end
          ClsMfhi: begin
            src_fixed[SRC_HI] = 1'b1;
            dst_en            = 1'b1;
            state_d           = StT0;
          end
          ClsMflo: begin
            src_fixed[SRC_LO] = 1'b1;
            dst_en            = 1'b1;
            state_d           = StT0;
          end
          ClsNop: begin
            state_d = StT0;
          end
          ClsHalt: begin
            state_d = StHalt;
          end
          default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
            state_d   = StHalt;
            illegal_d = 1'b1;
`else
            state_d   = StT0;
`endif
          end
        endcase
      end
      StT4: begin
        Zin     = 1'b1;
        alu_op  = alu_map(op);
        state_d = StT5;
        case (cls)
          ClsAluR: begin
            src_reg_en    = 1'b1;
            src_reg_field = rc;
          end
          ClsAluI: begin
            src_fixed[SRC_C] = 1'b1;
          end
          ClsUnary, ClsMulDiv: begin
            src_reg_en    = 1'b1;
            src_reg_field = rb;
          end
          default: ;
        endcase
      end
      StT5: begin
        src_fixed[SRC_ZLO] = 1'b1;
        if (cls == ClsMulDiv) begin
          LOin    = 1'b1;
          state_d = StT6;
        end else begin
          dst_en  = 1'b1;
          state_d = StT0;
        end
      end
      StT6: begin
        src_fixed[SRC_ZHI] = 1'b1;
        HIin               = 1'b1;
        state_d            = StT0;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  reg_select u_src_select (
    .field_i  (src_reg_field),
    .en_i     (src_reg_en),
    .onehot_o (src_reg_oh)
  );

  // Destination register is always the ra field.
  reg_select u_dst_select (
    .field_i  (ra),
    .en_i     (dst_en),
    .onehot_o (reg_in)
  );

  assign src_sel = src_fixed | {{(NSRC - NREG){1'b0}}, src_reg_oh};
  assign halted  = (state_q == StHalt);
  assign busy    = (state_q != StIdle) && (state_q != StHalt);

endmodule
